mul_seq: RTL

Multi-cycle 32x32 -> 64-bit multiplier controller for the MULT/MULTU path. It time-shares one internal RCA32 adder instance using shift-add iteration, followed by optional signed-correction subtract passes. The execute stage issues a start pulse and reads the HI/LO result on a done pulse. Area-oriented companion to the ripple-carry adder.

---
 rtl/mul_seq.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Sequential 32x32->64 shift-add multiplier (MULT/MULTU) built around a single
// ripple-carry adder, with two subtract passes that fix up signed operands.

module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  // Returns {carry_out, sum} of a one-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  logic [32:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign {carry_s[i+1], sum[i]} = full_add(a[i], b[i], carry_s[i]);
  end

  assign cout = carry_s[32];

endmodule

module mul_seq #(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_CORR_A = 3'd2,
    ST_CORR_B = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] m_r;
  logic [31:0] b_orig_r;
  logic [31:0] w_hi_r;
  logic [31:0] w_lo_r;
  logic [4:0]  cnt_r;
  logic        mode_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  logic [31:0] add_a_s;
  logic [31:0] add_b_s;
  logic        add_cin_s;
  logic [31:0] add_sum_s;
  logic        add_cout_s;
  logic [31:0] iter_hi_s;
  logic [31:0] iter_lo_s;
  logic        corr_en_s;
  logic [31:0] corr_hi_s;

  rca32 u_add (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Adder operand steering: accumulate in CALC, subtract B_orig / M in the corrections.
  always_comb begin
    add_a_s   = w_hi_r;
    add_b_s   = 32'd0;
    add_cin_s = 1'b0;
    case (state_r)
      ST_CALC: begin
        add_b_s   = w_lo_r[0] ? m_r : 32'd0;
        add_cin_s = 1'b0;
      end
      ST_CORR_A: begin
        add_b_s   = ~b_orig_r;
        add_cin_s = 1'b1;
      end
      ST_CORR_B: begin
        add_b_s   = ~m_r;
        add_cin_s = 1'b1;
      end
      default: begin
        add_b_s   = 32'd0;
        add_cin_s = 1'b0;
      end
    endcase
  end

  // One shift-add step: {cout,sum,W_lo} shifted right by one bit.
  always_comb begin
    iter_hi_s = {add_cout_s, add_sum_s[31:1]};
    iter_lo_s = {add_sum_s[0], w_lo_r[31:1]};
  end

  // Correction subtract applies only when the matching operand is negative.
  always_comb begin
    corr_en_s = (state_r == ST_CORR_A) ? m_r[31] : b_orig_r[31];
    corr_hi_s = corr_en_s ? add_sum_s : w_hi_r;
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      m_r      <= 32'd0;
      b_orig_r <= 32'd0;
      w_hi_r   <= 32'd0;
      w_lo_r   <= 32'd0;
      cnt_r    <= 5'd0;
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (flush) begin
            busy_r <= 1'b0;
          end else if (start) begin
            m_r      <= op_a;
            b_orig_r <= op_b;
            w_hi_r   <= 32'd0;
            w_lo_r   <= op_b;
            cnt_r    <= 5'd0;
            mode_r   <= sgn & SIGNED_EN;
            busy_r   <= 1'b1;
            state_r  <= ST_CALC;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CALC: begin
          if (flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            w_hi_r <= iter_hi_s;
            w_lo_r <= iter_lo_s;
            cnt_r  <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
              if (mode_r) begin
                state_r <= ST_CORR_A;
              end else begin
                hi_r    <= iter_hi_s;
                lo_r    <= iter_lo_s;
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
                state_r <= ST_DONE;
              end
            end
          end
        end
        ST_CORR_A: begin
          if (flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            w_hi_r  <= corr_hi_s;
            state_r <= ST_CORR_B;
          end
        end
        ST_CORR_B: begin
          if (flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            w_hi_r  <= corr_hi_s;
            hi_r    <= corr_hi_s;
            lo_r    <= w_lo_r;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
